// File: rtl/nonsym_write_test_sequencer.sv
// Sequences one pipe-in write test: FIFO flush, pattern reset, timed run, drain and verdict.
// Latency: every output is registered and reflects the transition taken at the previous okClk edge.
// Backpressure: none; each pipe_write/fifo_valid is counted in its own cycle, and the stall timer ends stuck tests.
//
// Ports:
//   okClk, reset_n            sole clock; synchronous active-low reset
//   start, abort              single-cycle control pulses
//   word_count[31:0]          expected 32-bit pipe words, latched on an accepted start
//   pipe_write                one strobe per 32-bit word entering the FIFO
//   fifo_empty, fifo_valid    FIFO read-side status (64-bit read words)
//   fifo_rst                  FIFO reset, high during FLUSH and while in reset
//   pattern_reset             one-cycle pulse in ARM to restart the checker pattern
//   timer_on, clk_counts      measurement window flag and 64-bit cycle count
//   words_seen, reads_seen    accepted pipe words / 64-bit reads observed
//   busy, done, fault, state  status: not idle, sticky success, sticky fault code, encoded state
module nonsym_write_test_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 8,
    parameter int unsigned STALL_LIMIT  = 1048576
) (
    input  logic        okClk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] word_count,
    input  logic        pipe_write,
    input  logic        fifo_empty,
    input  logic        fifo_valid,
    output logic        fifo_rst,
    output logic        pattern_reset,
    output logic        timer_on,
    output logic [63:0] clk_counts,
    output logic [31:0] words_seen,
    output logic [31:0] reads_seen,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_CONFIG  = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;
    localparam logic [1:0] FAULT_ABORT   = 2'd3;

    // Counter widths sized from the parameters; at least one bit each.
    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

    state_t          state_q;
    state_t          state_nxt;
    logic [31:0]     count_q;
    logic [FW-1:0]   flush_cnt;
    logic [SW-1:0]   stall_cnt;

    logic            in_meas;
    logic            flush_last;
    logic            words_reach;
    logic            drain_ok;
    logic            stall_expire;

    logic            accept;
    logic            cfg_err;
    logic            finish_ok;
    logic            timeout;
    logic            abort_hit;

    assign state = state_q;

    // Decode helpers; all are functions of registered state plus inputs and
    // only feed the next-state logic, never an output directly.
    always_comb begin
        in_meas      = (state_q == S_RUN) || (state_q == S_DRAIN);
        flush_last   = (flush_cnt == FW'(FLUSH_CYCLES - 1));
        // RUN leaves on the write that makes the updated count hit the target.
        words_reach  = pipe_write && ((words_seen + 32'd1) == count_q);
        // Each 64-bit read carries two pipe words, so the drain target is half.
        drain_ok     = (reads_seen == (count_q >> 1)) && fifo_empty && !fifo_valid;
        // The counter holds the idle cycles already seen; this cycle is idle too,
        // so the limit is reached when the incremented value would equal it.
        stall_expire = !pipe_write && !fifo_valid &&
                       ({1'b0, stall_cnt} + (SW+1)'(1) >= (SW+1)'(STALL_LIMIT));
    end

    // Next-state logic with abort taking priority over everything.
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        cfg_err   = 1'b0;
        finish_ok = 1'b0;
        timeout   = 1'b0;
        abort_hit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((word_count == 32'd0) || word_count[0]) begin
                        cfg_err = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_last) begin
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (words_reach) begin
                    state_nxt = S_DRAIN;
                end else if (stall_expire) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                // A clean finish wins over a stall that expires in the same cycle.
                if (drain_ok) begin
                    finish_ok = 1'b1;
                    state_nxt = S_IDLE;
                end else if (stall_expire) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if ((state_q != S_IDLE) && abort) begin
            abort_hit = 1'b1;
            finish_ok = 1'b0;
            timeout   = 1'b0;
            state_nxt = S_IDLE;
        end
    end

    // State and registered outputs. Mode outputs are decoded from the next
    // state so they line up with the state register after the same edge.
    always_ff @(posedge okClk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            fifo_rst      <= 1'b1;
            pattern_reset <= 1'b0;
            timer_on      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fault         <= FAULT_NONE;
            clk_counts    <= 64'd0;
            words_seen    <= 32'd0;
            reads_seen    <= 32'd0;
            count_q       <= 32'd0;
            flush_cnt     <= '0;
            stall_cnt     <= '0;
        end else begin
            state_q       <= state_nxt;
            fifo_rst      <= (state_nxt == S_FLUSH);
            pattern_reset <= (state_nxt == S_ARM);
            timer_on      <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            busy          <= (state_nxt != S_IDLE);

            // Counts cycles already spent in FLUSH; restarts on any other state.
            if (state_q == S_FLUSH) begin
                flush_cnt <= flush_cnt + FW'(1);
            end else begin
                flush_cnt <= '0;
            end

            if ((state_nxt != state_q) || pipe_write || fifo_valid) begin
                stall_cnt <= '0;
            end else if (in_meas) begin
                stall_cnt <= stall_cnt + SW'(1);
            end

            if (accept) begin
                count_q    <= word_count;
                clk_counts <= 64'd0;
                words_seen <= 32'd0;
                reads_seen <= 32'd0;
                done       <= 1'b0;
                fault      <= FAULT_NONE;
            end else begin
                // Counters run off the current state, so the cycle in which
                // abort or timeout fires is still counted; afterwards they hold.
                if (timer_on) begin
                    clk_counts <= clk_counts + 64'd1;
                end
                if (in_meas && pipe_write) begin
                    words_seen <= words_seen + 32'd1;
                end
                if (in_meas && fifo_valid) begin
                    reads_seen <= reads_seen + 32'd1;
                end
            end

            if (cfg_err) begin
                fault <= FAULT_CONFIG;
            end
            if (timeout) begin
                fault <= FAULT_TIMEOUT;
            end
            if (abort_hit) begin
                fault <= FAULT_ABORT;
            end
            if (finish_ok) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nonsym_write_test_sequencer.sv
// Directed bench for the write test sequencer: reset, config errors, nominal run,
// ignore rules, abort, timeout and reset mid-drain, with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_nonsym_write_test_sequencer;

    logic        okClk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] word_count;
    logic        pipe_write;
    logic        fifo_empty;
    logic        fifo_valid;
    logic        fifo_rst;
    logic        pattern_reset;
    logic        timer_on;
    logic [63:0] clk_counts;
    logic [31:0] words_seen;
    logic [31:0] reads_seen;
    logic        busy;
    logic        done;
    logic [1:0]  fault;
    logic [2:0]  state;

    int n_vec = 0;
    int n_bad = 0;
    int n_rst;

    nonsym_write_test_sequencer #(
        .FLUSH_CYCLES (8),
        .STALL_LIMIT  (16)
    ) dut (
        .okClk         (okClk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .word_count    (word_count),
        .pipe_write    (pipe_write),
        .fifo_empty    (fifo_empty),
        .fifo_valid    (fifo_valid),
        .fifo_rst      (fifo_rst),
        .pattern_reset (pattern_reset),
        .timer_on      (timer_on),
        .clk_counts    (clk_counts),
        .words_seen    (words_seen),
        .reads_seen    (reads_seen),
        .busy          (busy),
        .done          (done),
        .fault         (fault),
        .state         (state)
    );

    always #5 okClk = ~okClk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge okClk);
        #1;
    endtask

    // Accepted start, then FLUSH (8) and ARM (1): lands in the first RUN cycle.
    task automatic launch(input logic [31:0] wc);
        word_count = wc;
        start      = 1'b1;
        tick;
        start      = 1'b0;
        repeat (9) tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        word_count = 32'd0;
        pipe_write = 1'b0;
        fifo_empty = 1'b1;
        fifo_valid = 1'b0;

        // ---- reset values
        tick;
        chk("rst_state", state, 3'd0);
        chk("rst_fifo_rst", fifo_rst, 1'b1);
        chk("rst_flags", {pattern_reset, timer_on, busy, done, fault}, 6'd0);
        chk("rst_counters", {clk_counts, words_seen, reads_seen}, 128'd0);
        reset_n = 1'b1;
        tick;
        chk("rst_release_fifo_rst", fifo_rst, 1'b0);

        // ---- config errors: zero and odd word counts
        word_count = 32'd0;
        start      = 1'b1;
        tick;
        start = 1'b0;
        chk("cfg0_fault", fault, 2'd1);
        chk("cfg0_state_busy", {state, busy}, 4'd0);
        word_count = 32'd7;
        start      = 1'b1;
        tick;
        start = 1'b0;
        chk("cfg7_fault", fault, 2'd1);
        chk("cfg7_state_busy", {state, busy}, 4'd0);
        chk("cfg7_words", words_seen, 32'd0);
        tick;
        chk("cfg7_busy_after", busy, 1'b0);

        // ---- nominal: 8 words, 4 reads
        word_count = 32'd8;
        start      = 1'b1;
        tick;
        start = 1'b0;
        chk("nom_flush_state", state, 3'd1);
        chk("nom_fault_cleared", fault, 2'd0);
        chk("nom_busy", busy, 1'b1);
        n_rst = (fifo_rst === 1'b1) ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (fifo_rst === 1'b1) n_rst++;
            else break;
        end
        chk("nom_fifo_rst_cycles", n_rst, 8);
        chk("nom_arm_state", state, 3'd2);
        chk("nom_pattern_reset_on", pattern_reset, 1'b1);
        chk("nom_arm_timer", timer_on, 1'b0);
        tick;
        chk("nom_run_state", state, 3'd3);
        chk("nom_pattern_reset_off", pattern_reset, 1'b0);
        chk("nom_timer_on", timer_on, 1'b1);
        for (int i = 0; i < 8; i++) begin
            pipe_write = 1'b1;
            fifo_valid = (i == 7);
            fifo_empty = (i != 7);
            tick;
            if (i == 3) chk("nom_words_mid", {state, words_seen}, {3'd3, 32'd4});
        end
        pipe_write = 1'b0;
        chk("nom_drain_state", state, 3'd4);
        chk("nom_both_counted", {words_seen, reads_seen}, {32'd8, 32'd1});
        fifo_valid = 1'b1;
        fifo_empty = 1'b0;
        repeat (3) tick;
        chk("nom_drain_hold", {state, reads_seen}, {3'd4, 32'd4});
        fifo_valid = 1'b0;
        fifo_empty = 1'b1;
        tick;
        chk("nom_idle", {state, busy, timer_on}, {3'd0, 1'b0, 1'b0});
        chk("nom_done_fault", {done, fault}, {1'b1, 2'd0});
        chk("nom_counts", {words_seen, reads_seen}, {32'd8, 32'd4});
        chk("nom_clk_counts", clk_counts, 64'd12);

        // ---- abort in IDLE is ignored; counters hold
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tick;
        chk("idle_abort_ignored", {state, done, fault}, {3'd0, 1'b1, 2'd0});
        chk("idle_hold_clk", clk_counts, 64'd12);
        chk("idle_hold_words", words_seen, 32'd8);

        // ---- start during RUN ignored, then abort with a final write
        launch(32'd8);
        chk("abt_run_state", {state, done, clk_counts}, {3'd3, 1'b0, 64'd0});
        word_count = 32'd2;
        start      = 1'b1;
        pipe_write = 1'b1;
        tick;
        start = 1'b0;
        chk("abt_start_ignored", {state, busy, words_seen, fault}, {3'd3, 1'b1, 32'd1, 2'd0});
        abort = 1'b1;
        tick;
        abort      = 1'b0;
        pipe_write = 1'b0;
        chk("abt_state", {state, busy, timer_on}, {3'd0, 1'b0, 1'b0});
        chk("abt_fault", fault, 2'd3);
        chk("abt_final_word", words_seen, 32'd2);
        chk("abt_clk", clk_counts, 64'd2);

        // ---- timeout: 3 writes then silence
        launch(32'd8);
        pipe_write = 1'b1;
        repeat (3) tick;
        pipe_write = 1'b0;
        repeat (15) tick;
        chk("tmo_not_yet", {state, fault}, {3'd3, 2'd0});
        tick;
        chk("tmo_state", {state, busy}, {3'd0, 1'b0});
        chk("tmo_fault", fault, 2'd2);
        chk("tmo_words", words_seen, 32'd3);

        // ---- reset mid-DRAIN overrides a coincident abort
        launch(32'd4);
        pipe_write = 1'b1;
        repeat (4) tick;
        pipe_write = 1'b0;
        chk("rmd_drain_state", state, 3'd4);
        reset_n = 1'b0;
        abort   = 1'b1;
        tick;
        reset_n = 1'b1;
        abort   = 1'b0;
        chk("rmd_state", {state, busy, done, fault}, {3'd0, 1'b0, 1'b0, 2'd0});
        chk("rmd_fifo_rst", {fifo_rst, pattern_reset, timer_on}, 3'b100);
        chk("rmd_counters", {clk_counts, words_seen, reads_seen}, 128'd0);
        tick;
        chk("rmd_fifo_rst_drop", fifo_rst, 1'b0);

        // ---- clean rerun after reset: 2 words, 1 read
        launch(32'd2);
        pipe_write = 1'b1;
        repeat (2) tick;
        pipe_write = 1'b0;
        fifo_valid = 1'b1;
        fifo_empty = 1'b0;
        tick;
        fifo_valid = 1'b0;
        fifo_empty = 1'b1;
        tick;
        chk("rerun_result", {state, done, fault}, {3'd0, 1'b1, 2'd0});
        chk("rerun_counts", {words_seen, reads_seen}, {32'd2, 32'd1});
        chk("rerun_clk", clk_counts, 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
